// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder: loader FSM encoding and word width.
package memory_responder_pkg;

    localparam int MEM_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        RUN     = 2'd2
    } load_state_t;

endpackage

// File: rtl/memory_responder_if.sv
// Datapath bus (MAR/MDR strobes) and boot-loader byte stream seen by the memory responder.
// Handshake: a loader byte transfers on a rising edge where load_valid && load_ready; RAM strobes
// are single-cycle and always accepted in RUN, with mem_rvalid marking read data one cycle later.
interface memory_responder_if
    import memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
);

    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [MEM_DATA_WIDTH-1:0] mem_wdata;
    logic                      RAM_enable_read;
    logic                      RAM_enable_write;
    logic [MEM_DATA_WIDTH-1:0] mem_rdata;
    logic                      mem_rvalid;

    logic                      load_valid;
    logic [7:0]                load_byte;
    logic                      load_last;
    logic                      load_ready;

    modport master (
        output mem_addr, mem_wdata, RAM_enable_read, RAM_enable_write,
        output load_valid, load_byte, load_last,
        input  mem_rdata, mem_rvalid, load_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, RAM_enable_read, RAM_enable_write,
        input  load_valid, load_byte, load_last,
        output mem_rdata, mem_rvalid, load_ready
    );

endinterface

// File: rtl/memory_responder_mem_array.sv
// Single-port word RAM with synchronous write and registered synchronous read.
module memory_responder_mem_array
    import memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [MEM_DATA_WIDTH-1:0] wdata,
    input  logic                      re,
    output logic [MEM_DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset so a reset mid-load keeps earlier words.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// RAM responder for the control unit plus a boot loader that packs bytes into words from address 0.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    memory_responder_if.slave     bus,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  access_error,
    output load_state_t           dbg_state
);

    localparam logic [ADDR_WIDTH:0] LAST_WORD = {1'b0, {ADDR_WIDTH{1'b1}}};

    load_state_t               state;
    load_state_t               state_next;
    logic [7:0]                hi_reg;
    logic                      rvalid_q;

    logic                      ram_we;
    logic                      ram_re;
    logic [ADDR_WIDTH-1:0]     ram_addr;
    logic [MEM_DATA_WIDTH-1:0] ram_wdata;
    logic [MEM_DATA_WIDTH-1:0] ram_rdata;
    logic                      load_word;
    logic                      hi_capture;
    logic                      err_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOAD_HI;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD_HI: begin
                if (bus.load_valid) begin
                    state_next = bus.load_last ? RUN : LOAD_LO;
                end
            end
            LOAD_LO: begin
                // Filling the last address without load_last ends the load as an overflow.
                if (bus.load_valid) begin
                    if (bus.load_last || load_count == LAST_WORD) begin
                        state_next = RUN;
                    end else begin
                        state_next = LOAD_HI;
                    end
                end
            end
            RUN:     state_next = RUN;
            default: state_next = LOAD_HI;
        endcase
    end

    always_comb begin
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = bus.mem_addr;
        ram_wdata  = bus.mem_wdata;
        load_word  = 1'b0;
        hi_capture = 1'b0;
        err_set    = 1'b0;
        case (state)
            LOAD_HI: begin
                ram_addr = load_count[ADDR_WIDTH-1:0];
                if (bus.load_valid) begin
                    hi_capture = 1'b1;
                    // A final byte arriving as a high byte is padded into an odd-length word.
                    if (bus.load_last) begin
                        ram_we    = 1'b1;
                        ram_wdata = {bus.load_byte, 8'h00};
                        load_word = 1'b1;
                        err_set   = 1'b1;
                    end
                end
            end
            LOAD_LO: begin
                ram_addr = load_count[ADDR_WIDTH-1:0];
                if (bus.load_valid) begin
                    ram_we    = 1'b1;
                    ram_wdata = {hi_reg, bus.load_byte};
                    load_word = 1'b1;
                    err_set   = !bus.load_last && (load_count == LAST_WORD);
                end
            end
            RUN: begin
                // A write wins over a same-cycle read; the collision is flagged.
                ram_we  = bus.RAM_enable_write;
                ram_re  = bus.RAM_enable_read && !bus.RAM_enable_write;
                err_set = bus.RAM_enable_read && bus.RAM_enable_write;
            end
            default: ;
        endcase
        if (state != RUN && (bus.RAM_enable_read || bus.RAM_enable_write)) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_reg       <= '0;
            load_count   <= '0;
            access_error <= 1'b0;
            cpu_hold     <= 1'b1;
            rvalid_q     <= 1'b0;
        end else begin
            if (hi_capture) begin
                hi_reg <= bus.load_byte;
            end
            if (load_word) begin
                load_count <= load_count + 1'b1;
            end
            if (err_set) begin
                access_error <= 1'b1;
            end
            cpu_hold <= (state != RUN);
            rvalid_q <= ram_re;
        end
    end

    memory_responder_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (ram_wdata),
        .re      (ram_re),
        .rdata   (ram_rdata)
    );

    assign bus.mem_rdata  = ram_rdata;
    assign bus.mem_rvalid = rvalid_q;
    assign bus.load_ready = (state != RUN);
    assign dbg_state      = state;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: boot loading, RUN reads/writes, collisions, overflow and reset.
module tb_memory_responder;
    import memory_responder_pkg::*;

    localparam int AW = 8;

    logic          clk;
    logic          reset_n;
    logic          cpu_hold;
    logic [AW:0]   load_count;
    logic          access_error;
    load_state_t   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    memory_responder_if #(.ADDR_WIDTH(AW)) bus ();

    memory_responder #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .load_count   (load_count),
        .access_error (access_error),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.mem_addr         = '0;
        bus.mem_wdata        = '0;
        bus.RAM_enable_read  = 1'b0;
        bus.RAM_enable_write = 1'b0;
        bus.load_valid       = 1'b0;
        bus.load_byte        = '0;
        bus.load_last        = 1'b0;
    endtask

    task automatic apply_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input logic last);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        bus.load_last  = last;
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bus.mem_addr        = a;
        bus.RAM_enable_read = 1'b1;
        @(posedge clk);
        #1;
        bus.RAM_enable_read = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (bus.mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", bus.mem_rdata); end
        n_checks++; if (bus.mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", bus.mem_rvalid); end
        n_checks++; if (load_count !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", load_count); end
        n_checks++; if (access_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", access_error); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b expected 1", cpu_hold); end
        n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.load_ready); end
        n_checks++; if (dbg_state !== LOAD_HI) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_load_even();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b1);
        n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL load_state: got %0d expected 2", dbg_state); end
        n_checks++; if (load_count !== 9'd2) begin n_fail++; $display("FAIL load_count: got %0d expected 2", load_count); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL hold_at_entry: got %b expected 1", cpu_hold); end
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_run: got %b expected 0", bus.load_ready); end
        @(posedge clk); #1;
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL hold_after_entry: got %b expected 0", cpu_hold); end
        n_checks++; if (access_error !== 1'b0) begin n_fail++; $display("FAIL load_err: got %b expected 0", access_error); end
    endtask

    task automatic test_write_read();
        bus.mem_addr         = 8'd5;
        bus.mem_wdata        = 16'hBEEF;
        bus.RAM_enable_write = 1'b1;
        @(posedge clk); #1;
        bus.RAM_enable_write = 1'b0;
        bus.RAM_enable_read  = 1'b1;
        n_checks++; if (bus.mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rvalid: got %b expected 0", bus.mem_rvalid); end
        @(posedge clk); #1;
        bus.RAM_enable_read = 1'b0;
        n_checks++; if (bus.mem_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd5_data: got %h expected beef", bus.mem_rdata); end
        n_checks++; if (bus.mem_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd5_valid: got %b expected 1", bus.mem_rvalid); end
        @(posedge clk); #1;
        n_checks++; if (bus.mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd5_pulse: got %b expected 0", bus.mem_rvalid); end
        n_checks++; if (bus.mem_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd5_hold: got %h expected beef", bus.mem_rdata); end
    endtask

    task automatic test_back_to_back();
        bus.mem_addr        = 8'd0;
        bus.RAM_enable_read = 1'b1;
        @(posedge clk); #1;
        bus.mem_addr = 8'd1;
        n_checks++; if (bus.mem_rdata !== 16'h1234) begin n_fail++; $display("FAIL b2b_rd0: got %h expected 1234", bus.mem_rdata); end
        n_checks++; if (bus.mem_rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_v0: got %b expected 1", bus.mem_rvalid); end
        @(posedge clk); #1;
        bus.RAM_enable_read = 1'b0;
        n_checks++; if (bus.mem_rdata !== 16'hABCD) begin n_fail++; $display("FAIL b2b_rd1: got %h expected abcd", bus.mem_rdata); end
        n_checks++; if (bus.mem_rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_v1: got %b expected 1", bus.mem_rvalid); end
    endtask

    task automatic test_collision();
        bus.mem_addr         = 8'd2;
        bus.mem_wdata        = 16'h5555;
        bus.RAM_enable_read  = 1'b1;
        bus.RAM_enable_write = 1'b1;
        @(posedge clk); #1;
        bus.RAM_enable_read  = 1'b0;
        bus.RAM_enable_write = 1'b0;
        n_checks++; if (bus.mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL coll_rvalid: got %b expected 0", bus.mem_rvalid); end
        n_checks++; if (bus.mem_rdata !== 16'hABCD) begin n_fail++; $display("FAIL coll_rdata: got %h expected abcd", bus.mem_rdata); end
        n_checks++; if (access_error !== 1'b1) begin n_fail++; $display("FAIL coll_err: got %b expected 1", access_error); end
        do_read(8'd2);
        n_checks++; if (bus.mem_rdata !== 16'h5555) begin n_fail++; $display("FAIL coll_mem: got %h expected 5555", bus.mem_rdata); end
    endtask

    task automatic test_odd_load();
        apply_reset();
        n_checks++; if (access_error !== 1'b0) begin n_fail++; $display("FAIL odd_err_cleared: got %b expected 0", access_error); end
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        n_checks++; if (load_count !== 9'd2) begin n_fail++; $display("FAIL odd_count: got %0d expected 2", load_count); end
        n_checks++; if (access_error !== 1'b1) begin n_fail++; $display("FAIL odd_err: got %b expected 1", access_error); end
        n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL odd_state: got %0d expected 2", dbg_state); end
        do_read(8'd0);
        n_checks++; if (bus.mem_rdata !== 16'h0102) begin n_fail++; $display("FAIL odd_mem0: got %h expected 0102", bus.mem_rdata); end
        do_read(8'd1);
        n_checks++; if (bus.mem_rdata !== 16'h0300) begin n_fail++; $display("FAIL odd_mem1: got %h expected 0300", bus.mem_rdata); end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        n_checks++; if (load_count !== 9'd1) begin n_fail++; $display("FAIL mid_count: got %0d expected 1", load_count); end
        bus.RAM_enable_read = 1'b1;
        @(posedge clk); #1;
        bus.RAM_enable_read = 1'b0;
        n_checks++; if (access_error !== 1'b1) begin n_fail++; $display("FAIL strobe_in_load_err: got %b expected 1", access_error); end
        n_checks++; if (bus.mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL strobe_in_load_rvalid: got %b expected 0", bus.mem_rvalid); end
        send_byte(8'h33, 1'b0);
        reset_n = 1'b0;
        #1;
        n_checks++; if (dbg_state !== LOAD_HI) begin n_fail++; $display("FAIL mid_rst_state: got %0d expected 0", dbg_state); end
        n_checks++; if (load_count !== 9'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d expected 0", load_count); end
        n_checks++; if (access_error !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %b expected 0", access_error); end
        n_checks++; if (bus.mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_rdata: got %h expected 0000", bus.mem_rdata); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL mid_rst_hold: got %b expected 1", cpu_hold); end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b1);
        do_read(8'd0);
        n_checks++; if (bus.mem_rdata !== 16'h7788) begin n_fail++; $display("FAIL reload_mem0: got %h expected 7788", bus.mem_rdata); end
        do_read(8'd1);
        n_checks++; if (bus.mem_rdata !== 16'h0300) begin n_fail++; $display("FAIL retained_mem1: got %h expected 0300", bus.mem_rdata); end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            send_byte(b, 1'b0);
            send_byte(~b, 1'b0);
        end
        n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL ovf_state: got %0d expected 2", dbg_state); end
        n_checks++; if (load_count !== 9'h100) begin n_fail++; $display("FAIL ovf_count: got %0d expected 256", load_count); end
        n_checks++; if (access_error !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", access_error); end
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: got %b expected 0", bus.load_ready); end
        send_byte(8'h5A, 1'b0);
        n_checks++; if (load_count !== 9'h100) begin n_fail++; $display("FAIL ovf_ignored: got %0d expected 256", load_count); end
        do_read(8'd255);
        n_checks++; if (bus.mem_rdata !== 16'hFF00) begin n_fail++; $display("FAIL ovf_mem255: got %h expected ff00", bus.mem_rdata); end
        do_read(8'd128);
        n_checks++; if (bus.mem_rdata !== 16'h807F) begin n_fail++; $display("FAIL ovf_mem128: got %h expected 807f", bus.mem_rdata); end
    endtask

    initial begin
        drive_idle();
        reset_n = 1'b1;
        test_reset();
        test_load_even();
        test_write_read();
        test_back_to_back();
        test_collision();
        test_odd_load();
        test_reset_mid_load();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
